// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit engine and the receiver.
//   uart_tx_state_t           : transmit FSM state encoding
//   UART_DATA_BITS            : data bits per frame
//   UART_DEFAULT_CLKS_PER_BIT : default bit period (12 MHz / 115200)
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   restart : hold the timer at the start of a period
//   periods : number of bit periods per done pulse (1..3)
//   done    : single-cycle pulse on the last cycle of the final period
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [1:0] periods,
  output logic       done
);

  localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rep_q, rep_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == LAST);
    // A multi-period span is counted as whole bit periods, so the
    // cycle counter never needs to be wider than one bit period.
    done  = wrap && (rep_q == 2'(periods - 2'd1));
    cnt_d = cnt_q + 1'b1;
    rep_d = rep_q;
    if (restart || done) begin
      cnt_d = '0;
      rep_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      rep_d = rep_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rep_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO and sends them as
// 8N1 / 8N2 frames, LSB first.
//   clk              : system clock
//   reset            : asynchronous active-high reset
//   enable           : allows a new frame to start (sampled in IDLE only)
//   fifo_empty       : FIFO empty flag
//   fifo_data        : FIFO read data, valid the cycle after a rising request
//   fifo_read_active : FIFO read request (FIFO pops on its rising edge)
//   tx               : serial output, idle high
//   busy             : high whenever the engine is not IDLE
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_active,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      fra_q, fra_d;
  logic                      busy_q, busy_d;

  logic       timer_restart;
  logic [1:0] timer_periods;
  logic       bit_done;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(timer_restart),
    .periods(timer_periods),
    .done   (bit_done)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    tx_d          = tx_q;
    fra_d         = fra_q;
    timer_restart = 1'b0;
    timer_periods = 2'd1;

    case (state_q)
      ST_IDLE: begin
        timer_restart = 1'b1;
        tx_d          = 1'b1;
        if (enable && !fifo_empty) begin
          state_d = ST_FETCH_REQ;
          fra_d   = 1'b1;
        end
      end
      ST_FETCH_REQ: begin
        timer_restart = 1'b1;
        state_d       = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        // Timer is restarted here so the start bit gets a full period.
        timer_restart = 1'b1;
        shift_d       = fifo_data;
        fra_d         = 1'b0;
        tx_d          = 1'b0;
        state_d       = ST_START;
      end
      ST_START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_BIT) begin
            tx_d      = 1'b1;
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        timer_periods = 2'(STOP_BITS);
        if (bit_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      fra_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      fra_q     <= fra_d;
      busy_q    <= busy_d;
    end
  end

  assign tx               = tx_q;
  assign fifo_read_active = fra_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine.
// dut : CLKS_PER_BIT=4, STOP_BITS=1, fed by a small FIFO model.
// dut2: CLKS_PER_BIT=5, STOP_BITS=2, fed a constant byte.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  // FIFO model: pops on the rising edge of the read request, data valid next cycle
  logic [7:0] mem [16];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;
  logic [7:0] fifo_data = '0;
  logic       fra_prev = 1'b0;
  logic       fifo_empty;
  logic       fra, tx, busy;

  logic       enable2 = 1'b0;
  logic       empty2 = 1'b1;
  logic [7:0] data2 = 8'h80;
  logic       fra2, tx2, busy2;

  int cyc = 0;
  int busy_hi = 0;
  int fra_hi = 0;
  int busy2_hi = 0;
  int n_cmp = 0;
  int n_err = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  uart_tx_engine #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_active(fra), .tx(tx), .busy(busy)
  );

  uart_tx_engine #(.CLKS_PER_BIT(5), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .fifo_empty(empty2),
    .fifo_data(data2), .fifo_read_active(fra2), .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    fra_prev <= fra;
    if (fra && !fra_prev) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1)  busy_hi++;
    if (fra === 1'b1)   fra_hi++;
    if (busy2 === 1'b1) busy2_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  // Called at a negedge. Waits for the start bit, then checks every cycle
  // of the frame against the expected start/data/stop levels.
  task automatic capture(input bit sel, input int cpb, input int stops,
                         input logic [7:0] exp_byte, input string tag,
                         output int start_cyc);
    int   n;
    int   b;
    logic lvl;
    n         = 0;
    start_cyc = -1;
    while (cur_tx(sel) !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, (n < 300) ? 1 : 0, 1);
    if (n >= 300) return;
    start_cyc = cyc;
    for (int j = 0; j < (9 + stops) * cpb; j++) begin
      b = j / cpb;
      if (b == 0)      lvl = 1'b0;
      else if (b <= 8) lvl = exp_byte[b-1];
      else             lvl = 1'b1;
      chk($sformatf("%s_bit%0d_c%0d", tag, b, j % cpb), cur_tx(sel), lvl);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, s3, rc, viol, n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_fra", fra, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx2", tx2, 1);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("idle_empty_busy", busy, 0);

    // Single byte 0x55: busy spans 2 fetch cycles + 40 frame cycles
    busy_hi = 0;
    fra_hi  = 0;
    push(8'h55);
    capture(1'b0, 4, 1, 8'h55, "t1", s1);
    repeat (8) @(negedge clk);
    chk("t1_busy_cycles", busy_hi, 42);
    chk("t1_fra_cycles", fra_hi, 2);
    chk("t1_fifo_empty", fifo_empty, 1);

    // Three back-to-back bytes. Start-bit spacing = 40 frame cycles +
    // one IDLE cycle + FETCH_REQ + FETCH_WAIT = 43.
    fra_hi = 0;
    push(8'h00);
    push(8'hFF);
    push(8'hA3);
    capture(1'b0, 4, 1, 8'h00, "t2a", s1);
    capture(1'b0, 4, 1, 8'hFF, "t2b", s2);
    chk("t2_spacing_ab", s2 - s1, 43);
    capture(1'b0, 4, 1, 8'hA3, "t2c", s3);
    chk("t2_spacing_bc", s3 - s2, 43);
    repeat (4) @(negedge clk);
    chk("t2_fra_cycles", fra_hi, 6);
    chk("t2_fifo_empty", fifo_empty, 1);

    // enable low with data waiting: line stays idle, no read request
    enable = 1'b0;
    push(8'hC3);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || fra !== 1'b0) viol++;
    end
    chk("t3_held_idle", viol, 0);
    enable = 1'b1;
    rc     = cyc;
    capture(1'b0, 4, 1, 8'hC3, "t3", s1);
    chk("t3_start_latency", s1 - rc, 3);

    // Drop enable and refill mid-DATA: frame unchanged, nothing new starts
    push(8'h3C);
    fork
      capture(1'b0, 4, 1, 8'h3C, "t4", s1);
      begin
        repeat (22) @(negedge clk);
        enable = 1'b0;
        push(8'hEE);
        push(8'h5A);
      end
    join
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || fra !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("t4_no_new_frame", viol, 0);
    chk("t4_fifo_pending", fifo_empty, 0);

    // Asynchronous reset during data bit 4 of 0xEE (a 0 bit)
    enable = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start_seen", (n < 50) ? 1 : 0, 1);
    repeat (21) @(negedge clk);
    chk("t5_bit4_low", tx, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_tx", tx, 1);
    chk("t5_async_fra", fra, 0);
    chk("t5_async_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    capture(1'b0, 4, 1, 8'h5A, "t5", s1);
    chk("t5_fifo_empty", fifo_empty, 1);

    // Two stop bits, 5 clocks per bit, byte 0x80: 55-cycle frame, 10-cycle stop
    repeat (3) @(negedge clk);
    busy2_hi = 0;
    empty2   = 1'b0;
    enable2  = 1'b1;
    n = 0;
    while (fra2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_fetch_req", fra2, 1);
    empty2 = 1'b1;
    capture(1'b1, 5, 2, 8'h80, "t6", s1);
    repeat (5) @(negedge clk);
    chk("t6_busy_cycles", busy2_hi, 57);
    chk("t6_idle_tx", tx2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
